serv_rf_spram_arb: RTL

SERV_RF_SPRAM_ARB -- requirements
Module: serv_rf_spram_arb

---
 rtl/serv_rf_spram_arb.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/serv_rf_spram_arb.sv
// serv_rf_spram_arb
// Arbitrates one single-port SRAM (1-cycle read latency, active-low enables)
// between the SERV register-file read port, a one-entry SERV write buffer and
// an optional host/debug port.
// Priority per cycle: SERV read > buffered SERV write > host op.
// Reads never stall. Writes are parked in the buffer and drain in the first
// cycle without a read. A read that hits the parked write is forwarded.
// Optional host port: define SERV_RF_ARB_HOST_EN to build it; without the
// macro the host inputs are ignored and the host outputs are tied to zero.
module serv_rf_spram_arb #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 144,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  // SERV read port
  input  logic             i_rd_req,
  input  logic [AW-1:0]    i_raddr,
  output logic             o_rvalid,
  output logic [WIDTH-1:0] o_rdata,
  // SERV write port
  input  logic             i_wen,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_wready,
  // host (debug) port
  input  logic             i_host_req,
  input  logic             i_host_we,
  input  logic [AW-1:0]    i_host_addr,
  input  logic [WIDTH-1:0] i_host_wdata,
  output logic             o_host_ack,
  output logic [WIDTH-1:0] o_host_rdata,
  // single-port SRAM
  output logic             o_sram_cen_n,
  output logic             o_sram_wen_n,
  output logic [AW-1:0]    o_sram_addr,
  output logic [WIDTH-1:0] o_sram_d,
  input  logic [WIDTH-1:0] i_sram_q,
  // sticky write-overflow flag
  output logic             o_err
);

  // write buffer
  logic             buf_valid_q, buf_valid_d;
  logic [AW-1:0]    buf_addr_q,  buf_addr_d;
  logic [WIDTH-1:0] buf_data_q,  buf_data_d;
  // read response tracking
  logic             rvalid_q,    rvalid_d;
  logic             fwd_q,       fwd_d;
  logic [WIDTH-1:0] fwd_data_q,  fwd_data_d;
  // overflow flag
  logic             err_q,       err_d;

  // arbitration helpers
  logic drain_s;
  logic load_s;
  logic host_grant_s;

  // Buffer drains only in a cycle with no SERV read; a new write may be
  // accepted in that same cycle because the old entry leaves at the edge.
  always_comb begin
    drain_s  = buf_valid_q & ~i_rd_req;
    o_wready = ~buf_valid_q | drain_s;
    load_s   = i_wen & o_wready;
  end

  // Next-state for write buffer, read response and overflow flag.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    err_d       = err_q;
    if (load_s) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = i_waddr;
      buf_data_d  = i_wdata;
    end else if (drain_s) begin
      buf_valid_d = 1'b0;
    end else begin
      buf_valid_d = buf_valid_q;
    end
    if (i_wen & ~o_wready) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    // Forwarding looks at the buffer as it stands this cycle, so a write
    // arriving together with the read is not visible to that read.
    rvalid_d   = i_rd_req;
    fwd_d      = i_rd_req & buf_valid_q & (buf_addr_q == i_raddr);
    fwd_data_d = buf_data_q;
  end

  // Datapath state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      rvalid_q    <= 1'b0;
      fwd_q       <= 1'b0;
      fwd_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      rvalid_q    <= rvalid_d;
      fwd_q       <= fwd_d;
      fwd_data_q  <= fwd_data_d;
      err_q       <= err_d;
    end
  end

  assign o_rvalid = rvalid_q;
  assign o_rdata  = fwd_q ? fwd_data_q : i_sram_q;
  assign o_err    = err_q;

  // SRAM command from this cycle's arbitration; held idle while in reset.
  always_comb begin
    o_sram_cen_n = 1'b1;
    o_sram_wen_n = 1'b1;
    o_sram_addr  = '0;
    o_sram_d     = '0;
    if (!i_rst_n) begin
      o_sram_cen_n = 1'b1;
    end else if (i_rd_req) begin
      o_sram_cen_n = 1'b0;
      o_sram_addr  = i_raddr;
    end else if (buf_valid_q) begin
      o_sram_cen_n = 1'b0;
      o_sram_wen_n = 1'b0;
      o_sram_addr  = buf_addr_q;
      o_sram_d     = buf_data_q;
    end else if (host_grant_s) begin
      o_sram_cen_n = 1'b0;
      o_sram_wen_n = ~i_host_we;
      o_sram_addr  = i_host_addr;
      o_sram_d     = i_host_wdata;
    end else begin
      o_sram_cen_n = 1'b1;
    end
  end

`ifdef SERV_RF_ARB_HOST_EN

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_WAIT = 2'd1,
    H_ACK  = 2'd2
  } host_state_e;

  host_state_e      host_state_q, host_state_d;
  logic [WIDTH-1:0] host_rdata_q, host_rdata_d;

  // Host only gets the SRAM when SERV has no read and nothing is buffered.
  assign host_grant_s = (host_state_q == H_IDLE) & i_host_req & ~i_rd_req
                        & ~buf_valid_q & i_rst_n;

  // Host FSM next state and read-data capture.
  always_comb begin
    host_state_d = host_state_q;
    host_rdata_d = host_rdata_q;
    case (host_state_q)
      H_IDLE: begin
        if (host_grant_s) begin
          host_state_d = i_host_we ? H_ACK : H_WAIT;
        end else begin
          host_state_d = H_IDLE;
        end
      end
      H_WAIT: begin
        host_rdata_d = i_sram_q;
        host_state_d = H_ACK;
      end
      H_ACK: begin
        host_state_d = H_IDLE;
      end
      default: begin
        host_state_d = H_IDLE;
      end
    endcase
  end

  // Host FSM state and read-data registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      host_state_q <= H_IDLE;
      host_rdata_q <= '0;
    end else begin
      host_state_q <= host_state_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign o_host_ack   = (host_state_q == H_ACK);
  assign o_host_rdata = host_rdata_q;

`else

  logic unused_host;

  assign host_grant_s = 1'b0;
  assign o_host_ack   = 1'b0;
  assign o_host_rdata = '0;
  assign unused_host  = ^{i_host_req, i_host_we, i_host_addr, i_host_wdata};

`endif

endmodule
